// File: rtl/hazard_pkg.sv
// Shared types and control-vector constants for the pipeline hazard controller.
// Optional feature macro: HAZARD_ZERO_REG_EN (register 0 hard-wired to zero).
package hazard_pkg;

  // Execute-stage operand mux select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Hazard sequencer states.
  typedef enum logic {
    RUN,
    MEMWAIT
  } hz_state_t;

  // Per-stage stall/flush enables, bundled so each hazard case is one constant.
  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctl_t;

  // Nothing held, nothing squashed.
  localparam hz_ctl_t CtlNone    = 7'b0000000;
  // Freeze F..M while memory is busy; W gets a bubble so the stalled M result is not retired twice.
  localparam hz_ctl_t CtlMemWait = 7'b1111001;
  // Taken branch: squash the two younger instructions in D and E.
  localparam hz_ctl_t CtlBranch  = 7'b0000110;
  // Load-use: hold F/D one cycle and insert a bubble into E.
  localparam hz_ctl_t CtlLoadUse = 7'b1100010;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one execute-stage operand: the Memory-stage result beats the
// Writeback-stage result, otherwise the register file value is used.
// Optional feature macro: HAZARD_ZERO_REG_EN (address 0 never forwards).
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 4
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic [REG_AW-1:0] wa_m_i,
  input  logic              reg_write_m_i,
  input  logic [REG_AW-1:0] wa_w_i,
  input  logic              reg_write_w_i,
  output fwd_sel_t          sel_o
);

  logic hit_m;
  logic hit_w;

  // Compare source against both in-flight destinations and pick the youngest producer.
  always_comb begin
    hit_m = reg_write_m_i && (wa_m_i == src_i);
    hit_w = reg_write_w_i && (wa_w_i == src_i);
`ifdef HAZARD_ZERO_REG_EN
    if (src_i == '0) begin
      hit_m = 1'b0;
      hit_w = 1'b0;
    end
`endif
    if (hit_m) begin
      sel_o = FWD_MEM;
    end else if (hit_w) begin
      sel_o = FWD_WB;
    end else begin
      sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: operand forwarding selects, load-use
// bubbles, taken-branch squashes, multi-cycle data-memory waits with timeout, and a
// saturating count of fetch-stall cycles.
// Optional feature macro: HAZARD_ZERO_REG_EN (register 0 hard-wired to zero).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] Ra1D,
  input  logic [REG_AW-1:0] Ra2D,
  input  logic [REG_AW-1:0] Ra1E,
  input  logic [REG_AW-1:0] Ra2E,
  input  logic [REG_AW-1:0] WA3E,
  input  logic [REG_AW-1:0] WA3M,
  input  logic [REG_AW-1:0] WA3W,
  input  logic              RegWriteE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemtoRegE,
  input  logic              BranchTakenE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushW,
  output logic              MemErr,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam int unsigned      WaitW    = $clog2(MAX_WAIT);
  // Last wait-counter value before the access is abandoned.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  hz_state_t         state_q, state_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  hz_ctl_t           ctl;
  hz_ctl_t           ctl_out;
  fwd_sel_t          fwd_a;
  fwd_sel_t          fwd_b;
  logic              hit_1d;
  logic              hit_2d;
  logic              ldhaz;

  hazard_fwd_sel #(
    .REG_AW(REG_AW)
  ) u_fwd_a (
    .src_i        (Ra1E),
    .wa_m_i       (WA3M),
    .reg_write_m_i(RegWriteM),
    .wa_w_i       (WA3W),
    .reg_write_w_i(RegWriteW),
    .sel_o        (fwd_a)
  );

  hazard_fwd_sel #(
    .REG_AW(REG_AW)
  ) u_fwd_b (
    .src_i        (Ra2E),
    .wa_m_i       (WA3M),
    .reg_write_m_i(RegWriteM),
    .wa_w_i       (WA3W),
    .reg_write_w_i(RegWriteW),
    .sel_o        (fwd_b)
  );

  // Load-use detect: a load in E whose destination feeds either source of the D instruction.
  always_comb begin
    hit_1d = (WA3E == Ra1D);
    hit_2d = (WA3E == Ra2D);
`ifdef HAZARD_ZERO_REG_EN
    if (WA3E == '0) begin
      hit_1d = 1'b0;
      hit_2d = 1'b0;
    end
`endif
    ldhaz = MemtoRegE && RegWriteE && (hit_1d || hit_2d);
  end

  // Hazard sequencer: next state, wait counter and Mealy stall/flush vector.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = 1'b0;
    ctl        = CtlNone;
    case (state_q)
      RUN: begin
        // Memory wait outranks branch and load-use.
        if (MemReqM && !MemReadyM) begin
          ctl        = CtlMemWait;
          state_d    = MEMWAIT;
          wait_cnt_d = WaitW'(1);
        end else if (BranchTakenE) begin
          ctl = CtlBranch;
        end else if (ldhaz) begin
          ctl = CtlLoadUse;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          // Give up: release the pipeline and flag the error next cycle.
          state_d    = RUN;
          wait_cnt_d = '0;
          mem_err_d  = 1'b1;
        end else begin
          ctl        = CtlMemWait;
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted; stall counter saturates.
  always_comb begin
    ctl_out     = reset ? CtlNone : ctl;
    stall_cnt_d = stall_cnt_q;
    if (ctl_out.stall_f && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, wait counter, timeout flag and stall counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ForwardAE   = reset ? FWD_RF : fwd_a;
  assign ForwardBE   = reset ? FWD_RF : fwd_b;
  assign StallF      = ctl_out.stall_f;
  assign StallD      = ctl_out.stall_d;
  assign StallE      = ctl_out.stall_e;
  assign StallM      = ctl_out.stall_m;
  assign FlushD      = ctl_out.flush_d;
  assign FlushE      = ctl_out.flush_e;
  assign FlushW      = ctl_out.flush_w;
  assign MemErr      = mem_err_q;
  assign StallCycles = stall_cnt_q;

endmodule
